adder_rc_8_sequencer: RTL and testbench



---
 rtl/adder_rc_8_sequencer_pkg.sv | 14 +
 rtl/adder_rc_8_sequencer_settle_timer.sv | 28 ++
 rtl/adder_rc_8_sequencer.sv | 104 ++++++++++
 tb/tb_adder_rc_8_sequencer.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/adder_rc_8_sequencer_pkg.sv
// Shared definitions for the adder_rc_8 operand/result sequencer:
// state encoding and datapath widths of the external 8-bit ripple-carry adder.
package adder_rc_8_sequencer_pkg;

    localparam int OPND_W = 8;
    localparam int SUM_W  = 9;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

endpackage

// File: rtl/adder_rc_8_sequencer_settle_timer.sv
// Settle down-counter: loads a start value, counts down to zero and
// flags zero so the sequencer knows when the adder output is safe to sample.
module adder_rc_8_sequencer_settle_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/adder_rc_8_sequencer.sv
// Launches operand pairs onto an external combinational adder, waits a fixed
// number of cycles for the ripple to settle, then offers the captured sum downstream.
module adder_rc_8_sequencer
    import adder_rc_8_sequencer_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 4,
    parameter int DONE_W        = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OPND_W-1:0] in_a,
    input  logic [OPND_W-1:0] in_b,
    output logic [OPND_W-1:0] add_a,
    output logic [OPND_W-1:0] add_b,
    input  logic [SUM_W-1:0]  add_s,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [SUM_W-1:0]  out_sum,
    output logic              busy,
    output logic [DONE_W-1:0] done_count
);

    state_t state, state_nx;
    logic   accept, capture, finish;
    logic   cnt_zero;

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        capture  = 1'b0;
        finish   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (in_valid) begin
                    accept   = 1'b1;
                    state_nx = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_zero) begin
                    capture  = 1'b1;
                    state_nx = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    finish   = 1'b1;
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Loading SETTLE_CYCLES-1 makes capture land exactly SETTLE_CYCLES edges after launch.
    adder_rc_8_sequencer_settle_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept),
        .load_val (CNT_W'(SETTLE_CYCLES - 1)),
        .dec      ((state == ST_SETTLE) && !cnt_zero),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            add_a      <= '0;
            add_b      <= '0;
            out_sum    <= '0;
            out_valid  <= 1'b0;
            done_count <= '0;
        end else begin
            if (accept) begin
                add_a <= in_a;
                add_b <= in_b;
            end
            if (capture) begin
                out_sum   <= add_s;
                out_valid <= 1'b1;
            end
            if (finish) begin
                out_valid  <= 1'b0;
                done_count <= done_count + 1'b1;
            end
        end
    end

    assign in_ready = rst_n && (state == ST_IDLE);
    assign busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_adder_rc_8_sequencer.sv
// Randomized bench for adder_rc_8_sequencer with a behavioural adder and a
// transaction-level reference (sum = a+b, fixed latency, wrapping completion count).
module tb_adder_rc_8_sequencer;

    localparam int S      = 4;
    localparam int DONE_W = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0, out_ready = 1'b0;
    logic [7:0] in_a = '0, in_b = '0;
    logic       in_ready, out_valid, busy;
    logic [7:0] add_a, add_b;
    logic [8:0] add_s, out_sum;
    logic [DONE_W-1:0] done_count;

    logic       d1_in_valid = 1'b0, d1_out_ready = 1'b0;
    logic [7:0] d1_in_a = '0, d1_in_b = '0;
    logic       d1_in_ready, d1_out_valid, d1_busy;
    logic [7:0] d1_add_a, d1_add_b;
    logic [8:0] d1_add_s, d1_out_sum;
    logic [DONE_W-1:0] d1_done_count;

    int n_checks = 0, n_fail = 0;
    int exp_done = 0, cyc = 0, last_acc = -1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // External combinational adders
    assign add_s    = {1'b0, add_a} + {1'b0, add_b};
    assign d1_add_s = {1'b0, d1_add_a} + {1'b0, d1_add_b};

    adder_rc_8_sequencer #(.SETTLE_CYCLES(S), .CNT_W(4), .DONE_W(DONE_W)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .add_a(add_a), .add_b(add_b), .add_s(add_s),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .busy(busy), .done_count(done_count)
    );

    adder_rc_8_sequencer #(.SETTLE_CYCLES(1), .CNT_W(4), .DONE_W(DONE_W)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(d1_in_valid), .in_ready(d1_in_ready),
        .in_a(d1_in_a), .in_b(d1_in_b), .add_a(d1_add_a), .add_b(d1_add_b), .add_s(d1_add_s),
        .out_valid(d1_out_valid), .out_ready(d1_out_ready), .out_sum(d1_out_sum),
        .busy(d1_busy), .done_count(d1_done_count)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_add_a"}, add_a, 0);
        check({tag, "_add_b"}, add_b, 0);
        check({tag, "_out_sum"}, out_sum, 0);
        check({tag, "_done"}, done_count, 0);
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int stall, input bit b2b);
        int lat;
        logic [8:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        check("idle_ready", in_ready, 1);
        in_a = a; in_b = b; in_valid = 1'b1;
        out_ready = (stall == 0);
        tick;
        if (b2b && last_acc >= 0) check("interval", cyc - last_acc, S + 2);
        last_acc = cyc;
        // Fresh offers while busy must be ignored
        in_valid = b2b ? 1'b1 : 1'($urandom_range(0, 1));
        in_a = 8'($urandom); in_b = 8'($urandom);
        check("busy", busy, 1);
        check("not_ready", in_ready, 0);
        lat = 0;
        while (!out_valid && lat < 64) begin
            tick;
            lat++;
        end
        check("latency", lat, S);
        check("sum", out_sum, sum);
        check("add_a", add_a, a);
        check("add_b", add_b, b);
        for (int i = 0; i < stall; i++) begin
            tick;
            check("hold_valid", out_valid, 1);
            check("hold_sum", out_sum, sum);
            check("hold_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        tick;
        exp_done++;
        check("valid_drop", out_valid, 0);
        check("done", done_count, exp_done % (1 << DONE_W));
        check("ready_back", in_ready, 1);
        check("sum_kept", out_sum, sum);
        in_valid = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        // Reset held for 3 cycles
        rst_n = 1'b0;
        repeat (3) tick;
        check_reset_outputs("rst");
        rst_n = 1'b1;
        #1;
        check("rst_release_ready", in_ready, 1);

        run_op(8'hFF, 8'h01, 0, 1'b0);
        run_op(8'h55, 8'hAA, 10, 1'b0);

        // Reset two cycles into SETTLE drops the operation
        in_a = 8'($urandom); in_b = 8'($urandom); in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (2) tick;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        exp_done = 0;
        last_acc = -1;
        tick;
        rst_n = 1'b1;
        #1;
        check("midrst_ready", in_ready, 1);
        for (int i = 0; i < S + 2; i++) begin
            tick;
            check("midrst_no_valid", out_valid, 0);
        end
        out_ready = 1'b0;

        for (int i = 0; i < 300; i++) run_op(8'($urandom), 8'($urandom), 0, 1'b1);
        check("wrap_count", done_count, 44);

        last_acc = -1;
        for (int i = 0; i < 20; i++) run_op(8'($urandom), 8'($urandom), $urandom_range(0, 3), 1'b0);

        // Minimum-latency build
        check("d1_ready", d1_in_ready, 1);
        d1_in_a = 8'h80; d1_in_b = 8'h80; d1_in_valid = 1'b1; d1_out_ready = 1'b1;
        tick;
        d1_in_valid = 1'b0;
        check("d1_not_yet", d1_out_valid, 0);
        tick;
        check("d1_valid", d1_out_valid, 1);
        check("d1_sum", d1_out_sum, 9'h100);
        tick;
        check("d1_drop", d1_out_valid, 0);
        check("d1_done", d1_done_count, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
